// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory pipeline stage.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;
    localparam logic SEL_ALU   = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: one synchronous write port, one combinational read port.
module dmem_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_stage.sv
// MEM pipeline stage with configurable access wait-states and a stall output.
// Optional out-of-range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_stage
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] B_Bypass,
    input  logic [REG_W-1:0]  RW_ex,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel_ex,
    output logic [DATA_W-1:0] mux_ans_dm,
    output logic [REG_W-1:0]  RW_dm,
    output logic              stall_dm,
    output logic              fault_dm
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mux_q, mux_d;
    logic [REG_W-1:0]  rw_q, rw_d;

    logic [DATA_W-1:0] cap_ans_q, cap_b_q;
    logic [REG_W-1:0]  cap_reg_q;
    logic              cap_st_q, cap_sel_q;
    logic              cap_load;

    logic [DATA_W-1:0] acc_ans, acc_b, rd_data, load_data, acc_result;
    logic [REG_W-1:0]  acc_reg;
    logic              acc_st, acc_sel, acc_fire, acc_oob, ram_we;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic fault_q, fault_d;

    // The check uses the full ALU value, not just the low address bits.
    assign acc_oob = (64'(acc_ans) >= 64'(DEPTH));

    always_comb begin
        fault_d = fault_q | (acc_fire & acc_oob);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_dm = fault_q;
`else
    assign acc_oob  = 1'b0;
    assign fault_dm = 1'b0;
`endif

    // A pending access always uses the values captured on entry to BUSY.
    always_comb begin
        acc_ans = ans_ex;
        acc_b   = B_Bypass;
        acc_st  = mem_rw_ex;
        acc_sel = mem_mux_sel_ex;
        acc_reg = RW_ex;
        if (state_q == BUSY) begin
            acc_ans = cap_ans_q;
            acc_b   = cap_b_q;
            acc_st  = cap_st_q;
            acc_sel = cap_sel_q;
            acc_reg = cap_reg_q;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (acc_ans[AW-1:0]),
        .wdata_i (acc_b),
        .raddr_i (acc_ans[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign load_data  = acc_oob ? '0 : rd_data;
    assign acc_result = (acc_sel == SEL_ALU)   ? acc_ans :
                        (acc_st  == MEM_STORE) ? '0 : load_data;
    // Writes are blocked while reset is held so an aborted access never lands.
    assign ram_we     = acc_fire & (acc_st == MEM_STORE) & ~acc_oob & reset;
    assign stall_dm   = (state_q == BUSY);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mux_d    = mux_q;
        rw_d     = rw_q;
        cap_load = 1'b0;
        acc_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_en_ex) begin
                    mux_d = (mem_mux_sel_ex == SEL_ALU) ? ans_ex : '0;
                    rw_d  = RW_ex;
                end else if (WAIT_STATES == 0) begin
                    acc_fire = 1'b1;
                end else begin
                    cap_load = 1'b1;
                    cnt_d    = 4'(WAIT_STATES);
                    state_d  = BUSY;
                    rw_d     = '0;
                end
            end
            BUSY: begin
                rw_d = '0;
                if (cnt_q == 4'd1) begin
                    acc_fire = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc_fire) begin
            mux_d = acc_result;
            rw_d  = acc_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mux_q   <= '0;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            rw_q    <= rw_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_ans_q <= '0;
            cap_b_q   <= '0;
            cap_reg_q <= '0;
            cap_st_q  <= 1'b0;
            cap_sel_q <= 1'b0;
        end else if (cap_load) begin
            cap_ans_q <= ans_ex;
            cap_b_q   <= B_Bypass;
            cap_reg_q <= RW_ex;
            cap_st_q  <= mem_rw_ex;
            cap_sel_q <= mem_mux_sel_ex;
        end
    end

    assign mux_ans_dm = mux_q;
    assign RW_dm      = rw_q;

endmodule
